// File: rtl/bsg_link_upstream_credit_sched.sv
// Round-robin scheduler of NUM_REQ requesters onto one upstream link word stream, credit-gated.
// Define BSG_LINK_SCHED_PRIO0_EN to give requester 0 strict priority over the round-robin rest.
module bsg_link_upstream_credit_sched #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned CREDITS        = 16,
  parameter int unsigned TOKEN_DECIMATE = 8,
  localparam int unsigned IdW           = $clog2(NUM_REQ),
  localparam int unsigned CntW          = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     link_valid_o,
  output logic [WIDTH-1:0]         link_data_o,
  output logic [IdW-1:0]           link_id_o,
  input  logic                     link_ready_i,
  input  logic                     token_i,
  output logic [CntW-1:0]          credit_o,
  output logic                     err_o
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [IdW-1:0]    rr_q, rr_d;
  logic [CntW-1:0]   credit_q, credit_d;
  logic              err_q, err_d;

  logic              slot_free, grant_en, win_found, accept;
  logic [IdW-1:0]    win_idx;
  logic [CntW:0]     credit_sum;

  assign link_valid_o = (state_q == StFull);
  assign link_data_o  = data_q;
  assign link_id_o    = id_q;
  assign credit_o     = credit_q;
  assign err_o        = err_q;

  // A held word leaving this cycle frees the slot, giving one word per cycle.
  assign slot_free = (state_q == StEmpty) | (link_valid_o & link_ready_i);
  assign grant_en  = ~rst & slot_free & (credit_q != '0);
  assign accept    = grant_en & win_found;

`ifdef BSG_LINK_SCHED_PRIO0_EN
  logic [IdW-1:0] rr_base;
  // Pointer lives in 1..NUM_REQ-1; rebase so the search wraps over the non-zero requesters.
  assign rr_base = (rr_q == '0) ? '0 : rr_q - IdW'(1);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (req_valid_i[0]) begin
      win_found = 1'b1;
    end else begin
      for (int k = 0; k < int'(NUM_REQ) - 1; k++) begin
        if (!win_found && req_valid_i[1 + (int'(rr_base) + k) % (int'(NUM_REQ) - 1)]) begin
          win_found = 1'b1;
          win_idx   = IdW'(1 + (int'(rr_base) + k) % (int'(NUM_REQ) - 1));
        end
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!win_found && req_valid_i[(int'(rr_q) + k) % int'(NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IdW'((int'(rr_q) + k) % int'(NUM_REQ));
      end
    end
  end
`endif

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[win_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    rr_d    = rr_q;
    err_d   = err_q;

    case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (link_ready_i && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      data_d = req_data_i[int'(win_idx)*int'(WIDTH) +: WIDTH];
      id_d   = win_idx;
`ifdef BSG_LINK_SCHED_PRIO0_EN
      if (win_idx != '0) begin
        rr_d = (win_idx == IdW'(NUM_REQ - 1)) ? IdW'(1) : win_idx + IdW'(1);
      end
`else
      rr_d = (win_idx == IdW'(NUM_REQ - 1)) ? '0 : win_idx + IdW'(1);
`endif
    end

    // Credit is taken at accept; one extra bit catches overflow from token returns.
    credit_sum = {1'b0, credit_q} - (CntW+1)'(accept)
               + (token_i ? (CntW+1)'(TOKEN_DECIMATE) : '0);
    if (credit_sum > (CntW+1)'(CREDITS)) begin
      credit_d = CntW'(CREDITS);
      err_d    = 1'b1;
    end else begin
      credit_d = credit_sum[CntW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      data_q   <= '0;
      id_q     <= '0;
      rr_q     <= '0;
      credit_q <= CntW'(CREDITS);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_bsg_link_upstream_credit_sched.sv
// Self-checking bench: reference model + scoreboard for link words, a vector table, directed sequences.
module tb_bsg_link_upstream_credit_sched;
  localparam int NR = 2;
  localparam int W  = 64;
  localparam int CR = 16;
  localparam int TD = 8;
  localparam int IW = $clog2(NR);
  localparam int CW = $clog2(CR + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid_i = '0;
  logic [NR*W-1:0] req_data_i = '0;
  logic [NR-1:0]   req_ready_o;
  logic            link_valid_o;
  logic [W-1:0]    link_data_o;
  logic [IW-1:0]   link_id_o;
  logic            link_ready_i = 1'b1;
  logic            token_i = 1'b0;
  logic [CW-1:0]   credit_o;
  logic            err_o;

  bsg_link_upstream_credit_sched #(
    .NUM_REQ(NR), .WIDTH(W), .CREDITS(CR), .TOKEN_DECIMATE(TD)
  ) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .link_valid_o(link_valid_o), .link_data_o(link_data_o),
    .link_id_o(link_id_o), .link_ready_i(link_ready_i), .token_i(token_i),
    .credit_o(credit_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } word_t;

  typedef struct {
    logic [NR-1:0] v;
    logic          lr;
    logic          tok;
    int            exp_credit;
    logic [NR-1:0] exp_ready;
    logic          exp_err;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  word_t sb_q[$];
  int    grant_hist[$];
  int    accepts;
  logic  m_full;
  int    m_rr, m_credit;
  logic  m_err;
  logic [NR-1:0] s_ready;
  int    s_credit;
  logic  s_err;
  vec_t  tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_win(input logic [NR-1:0] v);
    int idx;
`ifdef BSG_LINK_SCHED_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < NR - 1; k++) begin
      idx = 1 + (((m_rr == 0) ? 0 : m_rr - 1) + k) % (NR - 1);
      if (v[idx]) return idx;
    end
`else
    for (int k = 0; k < NR; k++) begin
      idx = (m_rr + k) % NR;
      if (v[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  // One clock cycle: drive, check against the model at negedge, then advance the model.
  task automatic step(input logic [NR-1:0] v, input logic lr, input logic tok);
    int            win;
    logic [NR-1:0] exp_rdy;
    word_t         w;
    req_valid_i  = v;
    link_ready_i = lr;
    token_i      = tok;
    for (int i = 0; i < NR; i++) req_data_i[i*W +: W] = {$urandom, $urandom};
    @(negedge clk);
    win = -1;
    if ((!m_full || lr) && m_credit != 0) win = model_win(v);
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    s_ready  = req_ready_o;
    s_credit = int'(credit_o);
    s_err    = err_o;
    chk("req_ready", req_ready_o, exp_rdy);
    chk("credit", credit_o, m_credit);
    chk("link_valid", link_valid_o, m_full);
    chk("err", err_o, m_err);
    if (m_full && lr) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        w = sb_q.pop_front();
        chk("link_id", link_id_o, w.id);
        chk("link_data", link_data_o, w.data);
      end
    end
    if (win >= 0) begin
      w.id   = IW'(win);
      w.data = req_data_i[win*W +: W];
      sb_q.push_back(w);
      accepts++;
      grant_hist.push_back(win);
    end
    @(posedge clk);
    #1;
    m_credit = m_credit - ((win >= 0) ? 1 : 0) + (tok ? TD : 0);
    if (m_credit > CR) begin
      m_credit = CR;
      m_err    = 1'b1;
    end
    m_full = (win >= 0) || (m_full && !lr);
`ifdef BSG_LINK_SCHED_PRIO0_EN
    if (win > 0) m_rr = (win == NR - 1) ? 1 : win + 1;
`else
    if (win >= 0) m_rr = (win + 1) % NR;
`endif
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid_i  = '1;
    link_ready_i = 1'b1;
    token_i      = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("ready_in_rst", req_ready_o, '0);
      @(posedge clk);
      #1;
    end
    rst         = 1'b0;
    req_valid_i = '0;
    m_full = 1'b0; m_rr = 0; m_credit = CR; m_err = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    // Starting from a fresh reset: six single-requester accepts, then accept+token at credit 10.
    tbl[0] = '{2'b01, 1'b1, 1'b0, 16, 2'b01, 1'b0};
    tbl[1] = '{2'b01, 1'b1, 1'b0, 15, 2'b01, 1'b0};
    tbl[2] = '{2'b01, 1'b1, 1'b0, 14, 2'b01, 1'b0};
    tbl[3] = '{2'b01, 1'b1, 1'b0, 13, 2'b01, 1'b0};
    tbl[4] = '{2'b01, 1'b1, 1'b0, 12, 2'b01, 1'b0};
    tbl[5] = '{2'b01, 1'b1, 1'b0, 11, 2'b01, 1'b0};
    tbl[6] = '{2'b01, 1'b1, 1'b1, 10, 2'b01, 1'b0};
    tbl[7] = '{2'b00, 1'b1, 1'b0, 16, 2'b00, 1'b1};
    tbl[8] = '{2'b00, 1'b1, 1'b1, 16, 2'b00, 1'b1};
    tbl[9] = '{2'b10, 1'b1, 1'b0, 16, 2'b10, 1'b1};

    do_reset();
    chk("t1_credit", credit_o, 16);
    chk("t1_link_valid", link_valid_o, 0);
    chk("t1_err", err_o, 0);
    step('0, 1'b1, 1'b0);
    chk("t1_ready", s_ready, 0);

    accepts = 0;
    grant_hist.delete();
    repeat (20) step(2'b11, 1'b1, 1'b0);
    chk("t2_words", accepts, 16);
    for (int i = 0; i < 16; i++) begin
`ifdef BSG_LINK_SCHED_PRIO0_EN
      chk("t2_order", grant_hist[i], 0);
`else
      chk("t2_order", grant_hist[i], i % 2);
`endif
    end
    chk("t2_credit", credit_o, 0);
    repeat (4) step(2'b11, 1'b1, 1'b0);
    chk("t2_stall", accepts, 16);

    accepts = 0;
    step(2'b11, 1'b1, 1'b1);
    chk("t3_credit", credit_o, 8);
    repeat (12) step(2'b11, 1'b1, 1'b0);
    chk("t3_words", accepts, 8);
    chk("t3_credit0", credit_o, 0);

    step('0, 1'b1, 1'b1);
    accepts = 0;
    step(2'b11, 1'b0, 1'b0);
    chk("t4_held", link_valid_o, 1);
    repeat (5) begin
      step(2'b11, 1'b0, 1'b0);
      if (sb_q.size() == 1) begin
        chk("t4_hold_data", link_data_o, sb_q[0].data);
        chk("t4_hold_id", link_id_o, sb_q[0].id);
      end else begin
        chk("t4_sb_depth", sb_q.size(), 1);
      end
    end
    chk("t4_accepts", accepts, 1);
    chk("t4_credit", credit_o, 7);
    step('0, 1'b1, 1'b0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].lr, tbl[i].tok);
      chk("tbl_credit", s_credit, tbl[i].exp_credit);
      chk("tbl_ready", s_ready, tbl[i].exp_ready);
      chk("tbl_err", s_err, tbl[i].exp_err);
    end
    chk("t5_err_sticky", err_o, 1);

    do_reset();
    chk("rst_err_clear", err_o, 0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    chk("midop_held", link_valid_o, 1);
    do_reset();
    chk("midop_discard", link_valid_o, 0);
    chk("midop_credit", credit_o, 16);
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

`ifdef BSG_LINK_SCHED_PRIO0_EN
    grant_hist.delete();
    repeat (4) step(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("t6_prio0", grant_hist[i], 0);
    step(2'b10, 1'b1, 1'b0);
    chk("t6_req1", s_ready, 2'b10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
